// File: rtl/vend_sequencer_if.sv
// Handshake and status bundle between the vending sequencer and its neighbours.
// slave = sequencer side, master = coin front end / actuators side.
interface vend_sequencer_if #(
   parameter int unsigned STOCK_W = 4
) ();
   logic               coin_valid;
   logic [1:0]         coin_val;
   logic               coin_ready;
   logic               cancel;
   logic               restock;
   logic               disp_req;
   logic               disp_ack;
   logic               chg_req;
   logic [1:0]         chg_coin;
   logic               chg_ack;
   logic [3:0]         credit;
   logic [STOCK_W-1:0] stock;
   logic               sold_out;
   logic               busy;

   modport slave (
      input  coin_valid, coin_val, cancel, restock, disp_ack, chg_ack,
      output coin_ready, disp_req, chg_req, chg_coin, credit, stock, sold_out, busy
   );

   modport master (
      output coin_valid, coin_val, cancel, restock, disp_ack, chg_ack,
      input  coin_ready, disp_req, chg_req, chg_coin, credit, stock, sold_out, busy
   );
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: coin collection, dispense handshake, coin-by-coin
// change return, stock tracking, cancel/refund and inactivity timeout.
module vend_sequencer #(
   parameter int unsigned PRICE      = 3,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   vend_sequencer_if.slave   io_bus
);
   localparam int unsigned CREDIT_W = 4;
   localparam int unsigned TIMER_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_DISPENSE = 2'd2,
      S_CHANGE   = 2'd3
   } state_t;

   state_t              r_state,  w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [STOCK_W-1:0]  r_stock,  w_stock_nxt;
   logic [TIMER_W-1:0]  r_timer,  w_timer_nxt;

   logic [1:0]          w_coin_units;
   logic [1:0]          w_chg_units;
   logic                w_coin_ok;
   logic                w_coin_ready;
   logic [CREDIT_W-1:0] w_credit_sum;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_credit <= '0;
         r_stock  <= STOCK_W'(STOCK_INIT);
         r_timer  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_stock  <= w_stock_nxt;
         r_timer  <= w_timer_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_stock_nxt  = r_stock;
      w_timer_nxt  = r_timer;

      unique case (io_bus.coin_val)
         2'b01:   w_coin_units = 2'd1;
         2'b10:   w_coin_units = 2'd2;
         default: w_coin_units = 2'd0;
      endcase
      // Invalid codes are consumed but behave exactly like "no coin"
      w_coin_ok    = io_bus.coin_valid && w_coin_ready && (w_coin_units != 2'd0);
      w_credit_sum = r_credit + CREDIT_W'(w_coin_units);
      w_chg_units  = (r_credit >= CREDIT_W'(2)) ? 2'd2 : 2'd1;

      unique case (r_state)
         S_IDLE: begin
            if (io_bus.restock) w_stock_nxt = STOCK_W'(STOCK_INIT);
            if (w_coin_ok) begin
               w_credit_nxt = CREDIT_W'(w_coin_units);
               w_timer_nxt  = '0;
               w_state_nxt  = (CREDIT_W'(w_coin_units) >= CREDIT_W'(PRICE)) ? S_DISPENSE
                                                                           : S_COLLECT;
            end
         end
         S_COLLECT: begin
            // A coin arriving with cancel is credited before the cancel is judged
            if (w_coin_ok) begin
               w_credit_nxt = w_credit_sum;
               w_timer_nxt  = '0;
               if (w_credit_sum >= CREDIT_W'(PRICE)) w_state_nxt = S_DISPENSE;
               else if (io_bus.cancel)               w_state_nxt = S_CHANGE;
            end else if (io_bus.cancel || (r_timer == TIMER_W'(TIMEOUT - 1))) begin
               w_state_nxt = S_CHANGE;
            end else begin
               w_timer_nxt = r_timer + TIMER_W'(1);
            end
         end
         S_DISPENSE: begin
            if (io_bus.disp_ack) begin
               w_stock_nxt  = r_stock - STOCK_W'(1);
               w_credit_nxt = r_credit - CREDIT_W'(PRICE);
               w_state_nxt  = (r_credit != CREDIT_W'(PRICE)) ? S_CHANGE : S_IDLE;
            end
         end
         S_CHANGE: begin
            if (io_bus.chg_ack) begin
               w_credit_nxt = r_credit - CREDIT_W'(w_chg_units);
               if (r_credit == CREDIT_W'(w_chg_units)) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      w_coin_ready       = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && (r_stock != '0);
      io_bus.coin_ready  = w_coin_ready;
      io_bus.disp_req    = (r_state == S_DISPENSE);
      io_bus.chg_req     = (r_state == S_CHANGE);
      io_bus.chg_coin    = 2'b00;
      if (r_state == S_CHANGE)
         io_bus.chg_coin = (r_credit >= CREDIT_W'(2)) ? 2'b10 : 2'b01;
      io_bus.credit      = r_credit;
      io_bus.stock       = r_stock;
      io_bus.sold_out    = (r_stock == '0);
      io_bus.busy        = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
   end
endmodule
